input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Parametrised conditioning block for asynchronous board inputs (push-buttons, slide switches) feeding the core's MMIO input registers and the top-level LED/debug logic. Each channel is synchronised, debounced by a per-channel counter, and normalised to active-high. The block emits a stable level plus one-cycle press and release pulses, and keeps sticky pending flags that drive an interrupt request. It generalises the fixed 4-key/10-switch board inputs to N channels with configurable polarity and debounce time.

Parameters:
CHANNELS, 4, number of independent input channels.
DEBOUNCE_CYCLES, 1000000, number of stable cycles required before a level change is accepted (20 ms at 50 MHz). Must be at least 1.
SYNC_STAGES, 2, synchroniser flip-flop depth. Must be at least 2.
ACTIVE_LOW, 1, 1 means the raw input is active-low (KEY style); 0 means active-high (SW style). Applies to all channels.
REPEAT_DELAY, 25000000, cycles from press to the first auto-repeat pulse (optional feature only).
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset_n  input  1  synchronous, active-low reset.
raw_in  input  CHANNELS  asynchronous raw pin levels.
ack_mask  input  CHANNELS  one-cycle clear strobes for event_pending bits.
level  output  CHANNELS  debounced, active-high stable level.
press_pulse  output  CHANNELS  one-cycle pulse when level goes 0->1.
release_pulse  output  CHANNELS  one-cycle pulse when level goes 1->0.
event_pending  output  CHANNELS  sticky flag per channel, set by each press pulse.
irq  output  1  OR of all event_pending bits.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - synchroniser stages load the inactive value (normalised 0);
  - counters load 0;
  - level, press_pulse, release_pulse and event_pending load 0;
  - irq = 0.
  - Reset mid-debounce discards all count progress.
- Normalisation: s = sync_out XOR ACTIVE_LOW. All logic after the synchroniser works on s.
- Per-channel debounce counter:
  - width = max(1, $clog2(DEBOUNCE_CYCLES)).
  - If s == level: counter <= 0.
  - If s != level and counter == DEBOUNCE_CYCLES-1: level <= s and counter <= 0.
  - Otherwise: counter <= counter + 1.
  - The counter never wraps.
- Latency:
  - level changes exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value, provided the raw value stays constant over that interval.
  - Any glitch that returns s to level restarts the count from 0.
- Pulses:
  - press_pulse is registered and asserted on the same edge that level rises; release_pulse likewise on the edge that level falls.
  - Each pulse is high for exactly one cycle.
  - Press and release pulses are never simultaneously high on one channel.
- event_pending[i]:
  - set on any cycle where press_pulse[i] is 1;
  - cleared on an edge where ack_mask[i]=1;
  - if set and clear coincide, set wins (bit stays 1);
  - release_pulse does not affect it.
- irq: combinational OR of event_pending; no added latency.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- An input held active through reset release produces a press SYNC_STAGES + DEBOUNCE_CYCLES edges after reset_n rises.

Optional Feature:
Macro: INPUT_AUTOREPEAT_EN.
- Defined:
  - each channel has a repeat counter that clears on every level edge;
  - while level=1, press_pulse re-asserts for one cycle REPEAT_DELAY cycles after the original press, then every REPEAT_PERIOD cycles until level falls;
  - repeat pulses set event_pending exactly like real presses;
  - a release resets the repeat state.
- Not defined:
  - no repeat counters are instantiated;
  - REPEAT_DELAY and REPEAT_PERIOD are accepted but unused;
  - press_pulse fires only on the 0->1 level transition.

Test Plan:
Bench configuration for all scenarios: CHANNELS=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_PERIOD=5. Edge E is the first edge that samples the new raw value.
1. reset_n=0 for 2 cycles with raw_in=4'b1111 -> level, both pulse buses, event_pending = 4'b0000 and irq=0 after the first reset edge.
2. raw_in 1111->1110 at edge E, held -> level=0001, press_pulse=0001 at edge E+10 (one cycle only), event_pending[0]=1, irq=1.
3. raw_in[1] toggles every 3 cycles for 30 cycles, then returns to 1 -> level[1], press_pulse[1] and release_pulse[1] stay 0 throughout.
4. ack_mask=0001 for one cycle -> event_pending[0]=0 and irq=0 next cycle. Then press channel 2 and pulse ack_mask=0100 on the same edge as press_pulse[2] -> event_pending[2] remains 1.
5. raw_in[0] returns to 1 at edge E -> release_pulse[0]=1 and level[0]=0 at E+10; event_pending unchanged.
6. Hold raw_in[3]=0 for 50 cycles from edge E:
   - with INPUT_AUTOREPEAT_EN: press_pulse[3] at E+10, E+30, E+35, E+40, E+45;
   - without the macro: a single press_pulse[3] at E+10 only.

Source files
------------

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and normalise board inputs into level, pulses and irq.
// Optional auto-repeat of press pulses is built when INPUT_AUTOREPEAT_EN is defined.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] ack_mask,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] event_pending,
  output logic                irq
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("input_conditioner: illegal parameter value");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] s_q, s_d;
  logic [DEB_W-1:0]    cnt_q [CHANNELS];
  logic [DEB_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] pend_q, pend_d;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RPT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W    = (RPT_MAXV > 1) ? $clog2(RPT_MAXV) : 1;
  localparam logic [RPT_W-1:0] DLY_MAX = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_MAX = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt_q [CHANNELS];
  logic [RPT_W-1:0]    rpt_d [CHANNELS];
  // Set once the initial delay has elapsed; afterwards the period applies.
  logic [CHANNELS-1:0] rpt_phase_q, rpt_phase_d;
`endif

  always_comb begin
    sync_d[0] = raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    // Registered normalisation stage; everything downstream is active-high.
    s_d       = sync_q[SYNC_STAGES-1] ^ INACTIVE;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        cnt_d[i]     = '0;
        level_d[i]   = s_q[i];
        press_d[i]   = s_q[i];
        release_d[i] = ~s_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
`ifdef INPUT_AUTOREPEAT_EN
    for (int i = 0; i < CHANNELS; i++) begin
      rpt_d[i]       = rpt_q[i];
      rpt_phase_d[i] = rpt_phase_q[i];
      if (level_d[i] != level_q[i] || !level_q[i]) begin
        rpt_d[i]       = '0;
        rpt_phase_d[i] = 1'b0;
      end else if (rpt_q[i] == (rpt_phase_q[i] ? PER_MAX : DLY_MAX)) begin
        rpt_d[i]       = '0;
        rpt_phase_d[i] = 1'b1;
        press_d[i]     = 1'b1;
      end else begin
        rpt_d[i] = rpt_q[i] + RPT_W'(1);
      end
    end
`endif
    // A press landing on the same edge as its ack keeps the flag set.
    pend_d = (pend_q & ~ack_mask) | press_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INACTIVE;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      s_q       <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      pend_q    <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      s_q       <= s_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      pend_q    <= pend_d;
    end
  end

`ifdef INPUT_AUTOREPEAT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rpt_q[i] <= '0;
      end
      rpt_phase_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
      rpt_phase_q <= rpt_phase_d;
    end
  end
`endif

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_pending = pend_q;
  assign irq           = |pend_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner.
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] ack_mask;
  logic [3:0] level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] event_pending;
  logic       irq;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  input_conditioner #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .ack_mask     (ack_mask),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .event_pending(event_pending),
    .irq          (irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  logic [2:0]  acc;
  logic [63:0] seen;
  logic [63:0] exp6;

  initial begin
    reset_n  = 1'b0;
    raw_in   = 4'b1111;
    ack_mask = 4'b0000;

    // reset
    step(1);
    check_eq("rst_level", level, 4'b0000);
    check_eq("rst_press", press_pulse, 4'b0000);
    check_eq("rst_release", release_pulse, 4'b0000);
    check_eq("rst_pending", event_pending, 4'b0000);
    check_eq("rst_irq", irq, 1'b0);
    step(1);
    reset_n = 1'b1;
    step(12);
    check_eq("idle_level", level, 4'b0000);

    // press channel 0: visible at E+10
    raw_in = 4'b1110;
    step(10);
    check_eq("p0_early_level", level, 4'b0000);
    step(1);
    check_eq("p0_level", level, 4'b0001);
    check_eq("p0_press", press_pulse, 4'b0001);
    check_eq("p0_release", release_pulse, 4'b0000);
    check_eq("p0_pending", event_pending, 4'b0001);
    check_eq("p0_irq", irq, 1'b1);
    step(1);
    check_eq("p0_press_once", press_pulse, 4'b0000);
    check_eq("p0_level_hold", level, 4'b0001);

    // bouncing channel 1 never qualifies
    acc = 3'b000;
    for (int i = 0; i < 10; i++) begin
      raw_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(1);
        acc |= {level[1], press_pulse[1], release_pulse[1]};
      end
    end
    raw_in[1] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step(1);
      acc |= {level[1], press_pulse[1], release_pulse[1]};
    end
    check_eq("bounce_activity", acc, 3'b000);
    check_eq("bounce_level", level, 4'b0001);

    // ack clears pending; set wins over simultaneous ack
    ack_mask = 4'b0001;
    step(1);
    ack_mask = 4'b0000;
    check_eq("ack_pending", event_pending, 4'b0000);
    check_eq("ack_irq", irq, 1'b0);
    raw_in = 4'b1010;
    step(10);
    ack_mask = 4'b0100;
    step(1);
    ack_mask = 4'b0000;
    check_eq("p2_press", press_pulse, 4'b0100);
    check_eq("p2_set_wins", event_pending, 4'b0100);
    step(1);
    check_eq("p2_pending_hold", event_pending, 4'b0100);
    check_eq("p2_irq", irq, 1'b1);

    // release channel 0
    raw_in = 4'b1011;
    step(10);
    check_eq("r0_early_level", level, 4'b0101);
    step(1);
    check_eq("r0_release", release_pulse, 4'b0001);
    check_eq("r0_press", press_pulse, 4'b0000);
    check_eq("r0_level", level, 4'b0100);
    check_eq("r0_pending", event_pending, 4'b0100);
    step(1);
    check_eq("r0_release_once", release_pulse, 4'b0000);

    // hold channel 3 for 50 cycles
    raw_in = 4'b0011;
    seen = '0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      seen[k] = press_pulse[3];
    end
    raw_in = 4'b1011;
    exp6 = 64'd0;
    exp6[10] = 1'b1;
`ifdef INPUT_AUTOREPEAT_EN
    exp6[30] = 1'b1;
    exp6[35] = 1'b1;
    exp6[40] = 1'b1;
    exp6[45] = 1'b1;
`endif
    check_eq("hold3_press_map", seen, exp6);
    check_eq("hold3_pending", event_pending, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
